// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and width helpers for the N:1 pipelined mux
package mux_pkg;

  typedef enum logic {
    GRANT_STATIC = 1'b0,
    GRANT_RR     = 1'b1
  } grant_mode_e;

  localparam logic Y_RST_BIT = 1'b0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Channel ids are exactly wide enough to name every channel; N_CH >= 2 keeps this >= 1.
  function automatic int ch_id_w(input int n_ch);
    return clog2(n_ch);
  endfunction

endpackage

// File: rtl/mux_2_1.sv
// rtl/mux_2_1.sv - combinational 2:1 data selector used as one tree stage
module mux_2_1 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             s_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = s_i ? b_i : a_i;

endmodule

// File: rtl/mux_n_1_pipe.sv
// rtl/mux_n_1_pipe.sv - N:1 channel mux with registered output and valid/ready handshake
// MUX_RR_EN: round-robin grant instead of sel_in
module mux_n_1_pipe
  import mux_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int N_CH  = 4,
  localparam int SEL_W = ch_id_w(N_CH)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [N_CH*WIDTH-1:0] d_in,
  input  logic [N_CH-1:0]       valid_in,
  output logic [N_CH-1:0]       ready_out,
  input  logic [SEL_W-1:0]      sel_in,
  output logic [WIDTH-1:0]      y_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [SEL_W-1:0]      ch_out
);

  logic [SEL_W-1:0] grant;
  logic             free;
  logic             xfer;
  logic [WIDTH-1:0] node [2*N_CH-1];
  logic [WIDTH-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ch_q, ch_d;

  // Heap-ordered tree: node 0 is the root, leaves start at N_CH-1; deepest stage uses grant[0].
  for (genvar i = 0; i < N_CH; i++) begin : g_leaf
    assign node[N_CH-1+i] = d_in[i*WIDTH +: WIDTH];
  end

  for (genvar dp = 0; dp < SEL_W; dp++) begin : g_lvl
    for (genvar m = 0; m < (1 << dp); m++) begin : g_node
      localparam int K = (1 << dp) - 1 + m;
      mux_2_1 #(.WIDTH(WIDTH)) u_mux (
        .a_i(node[2*K+1]),
        .b_i(node[2*K+2]),
        .s_i(grant[SEL_W-1-dp]),
        .y_o(node[K])
      );
    end
  end

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] last_q, last_d;
  logic [SEL_W-1:0] idx;
  logic             found;
  logic             unused_sel;

  assign unused_sel = ^sel_in;

  // SEL_W-bit adds wrap modulo N_CH because N_CH is a power of two.
  always_comb begin
    grant = last_q + SEL_W'(1);
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = last_q + SEL_W'(k);
      if (!found && valid_in[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign last_d = xfer ? grant : last_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) last_q <= '0;
    else           last_q <= last_d;
  end
`else
  assign grant = sel_in;
`endif

  assign free      = !valid_q || ready_in;
  assign xfer      = valid_in[grant] && free;
  assign ready_out = (rst_n_in && free) ? (N_CH'(1) << grant) : '0;

  always_comb begin
    y_d     = y_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    if (xfer) begin
      y_d     = node[0];
      ch_d    = grant;
      valid_d = 1'b1;
    end else if (ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      y_q     <= {WIDTH{Y_RST_BIT}};
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  assign y_out     = y_q;
  assign ch_out    = ch_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// tb/tb_mux_n_1_pipe.sv - self-checking bench for mux_n_1_pipe (4- and 8-channel instances)
module tb_mux_n_1_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [31:0] d4 = '0;
  logic [3:0]  v4 = '0;
  logic [3:0]  ro4;
  logic [1:0]  sel4 = '0;
  logic [7:0]  y4;
  logic        vo4;
  logic        rin4 = 1'b0;
  logic [1:0]  ch4;

  logic [63:0] d8 = '0;
  logic [7:0]  v8 = '0;
  logic [7:0]  ro8;
  logic [2:0]  sel8 = '0;
  logic [7:0]  y8;
  logic        vo8;
  logic        rin8 = 1'b0;
  logic [2:0]  ch8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux_n_1_pipe #(.WIDTH(8), .N_CH(4)) u_dut4 (
    .clk_in(clk), .rst_n_in(rst_n), .d_in(d4), .valid_in(v4), .ready_out(ro4),
    .sel_in(sel4), .y_out(y4), .valid_out(vo4), .ready_in(rin4), .ch_out(ch4)
  );

  mux_n_1_pipe #(.WIDTH(8), .N_CH(8)) u_dut8 (
    .clk_in(clk), .rst_n_in(rst_n), .d_in(d8), .valid_in(v8), .ready_out(ro8),
    .sel_in(sel8), .y_out(y8), .valid_out(vo8), .ready_in(rin8), .ch_out(ch8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one entry per instance (0 = 4 channels, 1 = 8 channels).
  logic       m_valid [2] = '{1'b0, 1'b0};
  logic [7:0] m_y     [2] = '{8'h0, 8'h0};
  int         m_ch    [2] = '{0, 0};
  int         m_last  [2] = '{0, 0};

  function automatic int model_grant(input int n, input int sel, input logic [7:0] v, input int last);
`ifdef MUX_RR_EN
    for (int k = 1; k <= n; k++)
      if (v[(last + k) % n]) return (last + k) % n;
    return (last + 1) % n;
`else
    return sel;
`endif
  endfunction

  function automatic logic [7:0] vin(input int k);
    return (k != 0) ? v8 : {4'b0, v4};
  endfunction

  function automatic logic rin(input int k);
    return (k != 0) ? rin8 : rin4;
  endfunction

  function automatic int grant_of(input int k);
    return model_grant((k != 0) ? 8 : 4, (k != 0) ? int'(sel8) : int'(sel4), vin(k), m_last[k]);
  endfunction

  function automatic logic free_of(input int k);
    return !m_valid[k] || rin(k);
  endfunction

  function automatic logic [7:0] dbyte(input int k, input int g);
    return (k != 0) ? d8[g*8 +: 8] : d4[g*8 +: 8];
  endfunction

  function automatic logic [7:0] exp_ready(input int k);
    return (rst_n && free_of(k)) ? (8'd1 << grant_of(k)) : 8'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_valid[k] <= 1'b0;
        m_y[k]     <= 8'h0;
        m_ch[k]    <= 0;
        m_last[k]  <= 0;
      end else if (free_of(k) && vin(k)[grant_of(k)]) begin
        m_valid[k] <= 1'b1;
        m_y[k]     <= dbyte(k, grant_of(k));
        m_ch[k]    <= grant_of(k);
        m_last[k]  <= grant_of(k);
      end else if (rin(k)) begin
        m_valid[k] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("n4 ready_out", {4'b0, ro4}, exp_ready(0));
    check("n4 y_out", y4, m_y[0]);
    check("n4 valid_out", vo4, m_valid[0]);
    check("n4 ch_out", ch4, m_ch[0]);
    check("n8 ready_out", ro8, exp_ready(1));
    check("n8 y_out", y8, m_y[1]);
    check("n8 valid_out", vo8, m_valid[1]);
    check("n8 ch_out", ch8, m_ch[1]);
  end

`ifdef MUX_RR_EN
  int rr_all [5] = '{1, 2, 3, 0, 1};
  int rr_pair[4] = '{3, 0, 3, 0};
`endif

  initial begin
    #3;
    check("reset y_out", y4, 8'h00);
    check("reset valid_out", vo4, 1'b0);
    check("reset ready_out", ro4, 4'b0000);
    check("reset ch_out", ch4, 2'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

`ifndef MUX_RR_EN
    sel4 = 2'd2; d4[23:16] = 8'hA5; v4 = 4'b0100; rin4 = 1'b1;
    #1 check("static ready_out", ro4, 4'b0100);
    @(posedge clk); #1;
    rin4 = 1'b0; sel4 = 2'd0; v4 = 4'b0001; d4[7:0] = 8'h3C;
    #1;
    check("static y_out", y4, 8'hA5);
    check("static ch_out", ch4, 2'd2);
    check("static valid_out", vo4, 1'b1);
    check("stall ready_out", ro4, 4'b0000);
    repeat (3) begin
      @(posedge clk); #2;
      check("stall y_out", y4, 8'hA5);
      check("stall ready_out", ro4, 4'b0000);
    end
    rin4 = 1'b1;
    #1 check("unstall ready_out", ro4, 4'b0001);
    @(posedge clk); #2;
    check("ch0 y_out", y4, 8'h3C);
    check("ch0 ch_out", ch4, 2'd0);
    v4 = 4'b0000;
    @(posedge clk); #2;
    check("pop valid_out", vo4, 1'b0);
    check("pop y_out hold", y4, 8'h3C);
`else
    v4 = 4'b1111; rin4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("rr all ch_out", ch4, 2'(rr_all[i]));
    end
    v4 = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      check("rr pair ch_out", ch4, 2'(rr_pair[i]));
    end
    v4 = 4'b0010;
    @(posedge clk); #2;
    check("rr ch1 ch_out", ch4, 2'd1);
    rin4 = 1'b0; v4 = 4'b1111;
    #1 check("rr stall ready_out", ro4, 4'b0000);
    repeat (3) begin
      @(posedge clk); #2;
      check("rr stall ch_out", ch4, 2'd1);
      check("rr stall ready_out", ro4, 4'b0000);
    end
    rin4 = 1'b1;
    #1 check("rr resume ready_out", ro4, 4'b0100);
    @(posedge clk); #2;
    check("rr resume ch_out", ch4, 2'd2);
    v4 = 4'b0000;
    @(posedge clk); #2;
`endif

    sel4 = 2'd2; d4[23:16] = 8'h5A; v4 = 4'b0100; rin4 = 1'b1;
    @(posedge clk); #2;
    check("pre-reset valid_out", vo4, 1'b1);
    rin4 = 1'b0; v4 = 4'b0000;
    #1 rst_n = 1'b0;
    #1;
    check("async reset y_out", y4, 8'h00);
    check("async reset valid_out", vo4, 1'b0);
    check("async reset ready_out", ro4, 4'b0000);
    check("async reset ch_out", ch4, 2'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    sel8 = 3'd5; rin8 = 1'b1; v8 = 8'h20; d8[47:40] = 8'h10;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      d8[47:40] = 8'(8'h11 + i);
      #1;
      check("tput y_out", y8, 64'(8'h10 + i));
      check("tput valid_out", vo8, 1'b1);
      check("tput ch_out", ch8, 3'd5);
    end
    v8 = 8'h00;
    @(posedge clk); #2;
    check("tput drain valid_out", vo8, 1'b0);

    @(posedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
